clock_mode_ctrl: RTL and testbench
==================================

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive clk cycles a synchronized key must hold a new level before it is accepted.
REQ-002 SHALL have parameter RING_SECS, default 30: tick_1hz pulses after which ring self-clears.
REQ-003 SHALL have port clk, input, 1: system clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port tick_1hz, input, 1: one-cycle pulse per second, synchronous to clk.
REQ-006 SHALL have ports btn_mode, btn_inc, btn_stop, input, 1 each: raw, asynchronous, bouncing keys, active-high.
REQ-007 SHALL have port cur_time, input, 24: BCD {hr_t,hr_u,min_t,min_u,sec_t,sec_u} from the time counter.
REQ-008 SHALL have port run_en, output, 1: time counter is permitted to advance.
REQ-009 SHALL have ports inc_hour, inc_min, inc_sec, output, 1 each: one-cycle adjust pulses to the time counter.
REQ-010 SHALL have port alarm_time, output, 16: BCD {hr_t,hr_u,min_t,min_u}.
REQ-011 SHALL have port alarm_en, output, 1: alarm armed.
REQ-012 SHALL have port ring, output, 1: buzzer drive.
REQ-013 SHALL have port mode, output, 3: current state code.
REQ-014 SHALL have port blink, output, 1: display blink for the field being set.

Function
REQ-015 Each key SHALL pass through a 2-FF synchronizer.
REQ-016 After synchronization, the debounced level SHALL change only after the synchronized value has differed from it for DEB_CYCLES consecutive cycles; any return to the debounced level before then SHALL restart the count.
REQ-017 A press event SHALL be a one-cycle pulse in the cycle after the debounced level rises 0->1; releases SHALL generate no event.
REQ-018 The FSM SHALL have states RUN=0, SET_HR=1, SET_MIN=2, SET_SEC=3, AL_HR=4, AL_MIN=5; mode SHALL equal the state code, and codes 6-7 SHALL go to RUN on the next cycle.
REQ-019 Each mode press SHALL advance the state cyclically RUN->SET_HR->SET_MIN->SET_SEC->AL_HR->AL_MIN->RUN.
REQ-020 run_en SHALL be 1 in RUN only (combinational from state).
REQ-021 An inc press SHALL act by state:
- SET_HR: inc_hour pulses for exactly one cycle, one cycle after the event.
- SET_MIN: inc_min pulses likewise.
- SET_SEC: inc_sec pulses likewise.
- AL_HR: alarm hour increments, wrapping 23->00 (09->10, 19->20).
- AL_MIN: alarm minute increments, wrapping 59->00.
- RUN with ring=0: toggles alarm_en.
- RUN with ring=1: ignored.
REQ-022 If mode and inc events occur in the same cycle, mode SHALL take effect and inc SHALL be discarded.
REQ-023 Only one inc_* output SHALL ever be high in a given cycle.
REQ-024 match SHALL be defined as alarm_en=1, state RUN, cur_time[23:8]=alarm_time and cur_time[7:0]=8'h00.
REQ-025 ring SHALL set on the cycle after match rises 0->1; a match that stays high SHALL NOT retrigger ring.
REQ-026 While ring=1, a counter SHALL count tick_1hz pulses, and ring SHALL clear on the cycle after the RING_SECS-th pulse.
REQ-027 ring SHALL clear on the cycle after any of: a stop press, alarm_en going to 0, or leaving RUN; a stop press while ring=0 SHALL have no effect.
REQ-028 If a clear condition and a set condition fall in the same cycle, the clear SHALL win.
REQ-029 blink SHALL toggle on each tick_1hz in states other than RUN, SHALL be 0 in RUN, and SHALL be forced to 0 on every state change.

Reset
REQ-030 While rst=0, all outputs SHALL take their reset values asynchronously: mode=0, run_en=1, inc_hour=inc_min=inc_sec=0, alarm_time=16'h0000, alarm_en=0, ring=0, blink=0.
REQ-031 While rst=0, the synchronizers, debounced levels and all counters SHALL be 0.
REQ-032 A reset asserted mid-ring or mid-adjust SHALL abort the operation; no inc pulse or ring SHALL appear after rst releases until a new event occurs.

Verification
REQ-033 Bounce test: btn_inc toggles every 2 cycles for 20 cycles, then holds high, in state SET_MIN -> exactly one inc_min pulse, within DEB_CYCLES+4 cycles of the final rising edge.
REQ-034 Mode cycle test: six mode presses from reset -> mode steps 1,2,3,4,5,0; run_en=0 from the first press until the sixth.
REQ-035 Alarm wrap test: in AL_HR, starting from 23, one inc press -> alarm_time[15:8]=8'h00; in AL_MIN, starting from 59, one inc press -> alarm_time[7:0]=8'h00.
REQ-036 Alarm trigger test: alarm_time=16'h0730, alarm_en=1, cur_time stepped 07:29:59->07:30:00 -> ring=1; 30 further ticks with cur_time held -> ring=0, with no retrigger.
REQ-037 Stop test: stop press during ring -> ring=0 and alarm_en remains 1; mode and inc pressed in the same cycle from RUN -> mode=1 and no inc pulse.
REQ-038 Reset test: rst=0 during ring with mode=0 -> all outputs take their reset values immediately, with no clock required.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Mode, adjust and alarm controller for a BCD wall clock: debounces the three keys,
// sequences the set modes, pulses the time-counter adjust strobes and owns the buzzer.
module clock_mode_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int RING_SECS  = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_stop,
    input  logic [23:0] cur_time,
    output logic        run_en,
    output logic        inc_hour,
    output logic        inc_min,
    output logic        inc_sec,
    output logic [15:0] alarm_time,
    output logic        alarm_en,
    output logic        ring,
    output logic [2:0]  mode,
    output logic        blink
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int RW = $clog2(RING_SECS + 1);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_SET_SEC = 3'd3,
        ST_AL_HR   = 3'd4,
        ST_AL_MIN  = 3'd5
    } state_t;

    state_t        state;
    logic [2:0]    keys;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_d;
    logic [2:0]    press;
    logic [DW-1:0] deb_cnt [3];
    logic [RW-1:0] ring_cnt;
    logic          match;
    logic          match_q;
    logic          mode_ev;
    logic          inc_ev;
    logic          stop_ev;
    logic          state_chg;
    logic          ring_clr;
    logic          ring_set;

    // Key order within the vectors: bit 0 mode, bit 1 inc, bit 2 stop.
    assign keys = {btn_stop, btn_inc, btn_mode};

    // NOTE: the per-key counter array is plain flops, so it is reset with everything else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb & ~deb_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign mode_ev = press[0];
    assign inc_ev  = press[1];
    assign stop_ev = press[2];

    assign mode      = state;
    assign run_en    = (state == ST_RUN);
    assign state_chg = mode_ev || (mode > 3'd5);

    assign match = alarm_en && run_en && (cur_time[23:8] == alarm_time) &&
                   (cur_time[7:0] == 8'h00);

    // Leaving RUN (any mode press while in RUN) counts as a clear in the same cycle.
    assign ring_clr = (stop_ev && ring) || !alarm_en || !run_en || mode_ev;
    assign ring_set = match && !match_q;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // NOTE: every register here uses <= so all decisions see the pre-edge state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            inc_hour   <= 1'b0;
            inc_min    <= 1'b0;
            inc_sec    <= 1'b0;
            alarm_time <= 16'h0000;
            alarm_en   <= 1'b0;
            ring       <= 1'b0;
            ring_cnt   <= '0;
            match_q    <= 1'b0;
            blink      <= 1'b0;
        end else begin
            inc_hour <= 1'b0;
            inc_min  <= 1'b0;
            inc_sec  <= 1'b0;
            match_q  <= match;

            // A mode press always wins; the inc event of the same cycle is dropped.
            case (state)
                ST_RUN: begin
                    if (mode_ev) begin
                        state <= ST_SET_HR;
                    end else if (inc_ev && !ring) begin
                        alarm_en <= ~alarm_en;
                    end
                end
                ST_SET_HR: begin
                    if (mode_ev) begin
                        state <= ST_SET_MIN;
                    end else if (inc_ev) begin
                        inc_hour <= 1'b1;
                    end
                end
                ST_SET_MIN: begin
                    if (mode_ev) begin
                        state <= ST_SET_SEC;
                    end else if (inc_ev) begin
                        inc_min <= 1'b1;
                    end
                end
                ST_SET_SEC: begin
                    if (mode_ev) begin
                        state <= ST_AL_HR;
                    end else if (inc_ev) begin
                        inc_sec <= 1'b1;
                    end
                end
                ST_AL_HR: begin
                    if (mode_ev) begin
                        state <= ST_AL_MIN;
                    end else if (inc_ev) begin
                        alarm_time[15:8] <= bcd_inc(alarm_time[15:8], 8'h23);
                    end
                end
                ST_AL_MIN: begin
                    if (mode_ev) begin
                        state <= ST_RUN;
                    end else if (inc_ev) begin
                        alarm_time[7:0] <= bcd_inc(alarm_time[7:0], 8'h59);
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase

            if (ring_clr) begin
                ring     <= 1'b0;
                ring_cnt <= '0;
            end else if (ring_set) begin
                ring     <= 1'b1;
                ring_cnt <= '0;
            end else if (ring && tick_1hz) begin
                if (ring_cnt == RW'(RING_SECS - 1)) begin
                    ring     <= 1'b0;
                    ring_cnt <= '0;
                end else begin
                    ring_cnt <= ring_cnt + RW'(1);
                end
            end

            if (state_chg || run_en) begin
                blink <= 1'b0;
            end else if (tick_1hz) begin
                blink <= ~blink;
            end
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: a table of key presses with expected mode and
// alarm state, followed by hand-written bounce, wrap, ring, stop and reset sequences.
module tb_clock_mode_ctrl;

    localparam int DEB   = 4;
    localparam int RSECS = 30;

    localparam logic [2:0] KM = 3'b001;
    localparam logic [2:0] KI = 3'b010;
    localparam logic [2:0] KS = 3'b100;

    typedef struct packed {
        logic [2:0]  keys;
        logic [2:0]  mode;
        logic        run_en;
        logic [15:0] alarm;
        logic        al_en;
        logic [2:0]  inc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_stop = 1'b0;
    logic [23:0] cur_time = 24'h000000;
    logic        run_en;
    logic        inc_hour;
    logic        inc_min;
    logic        inc_sec;
    logic [15:0] alarm_time;
    logic        alarm_en;
    logic        ring;
    logic [2:0]  mode;
    logic        blink;

    int   checks = 0;
    int   errors = 0;
    int   cnt_h;
    int   cnt_m;
    int   cnt_s;
    logic multi_hot;
    vec_t vecs [14];
    int   hr;
    int   mn;
    int   first;

    always #5 clk = ~clk;

    clock_mode_ctrl #(.DEB_CYCLES(DEB), .RING_SECS(RSECS)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_stop   (btn_stop),
        .cur_time   (cur_time),
        .run_en     (run_en),
        .inc_hour   (inc_hour),
        .inc_min    (inc_min),
        .inc_sec    (inc_sec),
        .alarm_time (alarm_time),
        .alarm_en   (alarm_en),
        .ring       (ring),
        .mode       (mode),
        .blink      (blink)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic clear_counts();
        cnt_h = 0;
        cnt_m = 0;
        cnt_s = 0;
        multi_hot = 1'b0;
    endtask

    // One clock, sampled 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cnt_h += int'(inc_hour);
            cnt_m += int'(inc_min);
            cnt_s += int'(inc_sec);
            if (int'(inc_hour) + int'(inc_min) + int'(inc_sec) > 1) multi_hot = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1 tick_1hz = 1'b1;
        @(posedge clk);
        #1 tick_1hz = 1'b0;
    endtask

    // Clean press: hold long enough to debounce and act, then release and settle.
    task automatic press(input logic [2:0] keys);
        clear_counts();
        {btn_stop, btn_inc, btn_mode} = keys;
        step(DEB + 6);
        {btn_stop, btn_inc, btn_mode} = 3'b000;
        step(DEB + 6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{KM, 3'd1, 1'b0, 16'h0000, 1'b0, 3'b000};
        vecs[1]  = '{KI, 3'd1, 1'b0, 16'h0000, 1'b0, 3'b100};
        vecs[2]  = '{KM, 3'd2, 1'b0, 16'h0000, 1'b0, 3'b000};
        vecs[3]  = '{KI, 3'd2, 1'b0, 16'h0000, 1'b0, 3'b010};
        vecs[4]  = '{KM, 3'd3, 1'b0, 16'h0000, 1'b0, 3'b000};
        vecs[5]  = '{KI, 3'd3, 1'b0, 16'h0000, 1'b0, 3'b001};
        vecs[6]  = '{KM, 3'd4, 1'b0, 16'h0000, 1'b0, 3'b000};
        vecs[7]  = '{KI, 3'd4, 1'b0, 16'h0100, 1'b0, 3'b000};
        vecs[8]  = '{KM, 3'd5, 1'b0, 16'h0100, 1'b0, 3'b000};
        vecs[9]  = '{KI, 3'd5, 1'b0, 16'h0101, 1'b0, 3'b000};
        vecs[10] = '{KM, 3'd0, 1'b1, 16'h0101, 1'b0, 3'b000};
        vecs[11] = '{KI, 3'd0, 1'b1, 16'h0101, 1'b1, 3'b000};
        vecs[12] = '{KI, 3'd0, 1'b1, 16'h0101, 1'b0, 3'b000};
        vecs[13] = '{KS, 3'd0, 1'b1, 16'h0101, 1'b0, 3'b000};

        // Reset values while rst is held low.
        #3;
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_run_en", 32'(run_en), 32'd1);
        check("rst_inc", 32'({inc_hour, inc_min, inc_sec}), 32'd0);
        check("rst_alarm_time", 32'(alarm_time), 32'h0000);
        check("rst_alarm_en", 32'(alarm_en), 32'd0);
        check("rst_ring", 32'(ring), 32'd0);
        check("rst_blink", 32'(blink), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        clear_counts();
        step(3);

        for (int v = 0; v < 14; v++) begin
            press(vecs[v].keys);
            check($sformatf("v%0d_mode", v), 32'(mode), 32'(vecs[v].mode));
            check($sformatf("v%0d_run_en", v), 32'(run_en), 32'(vecs[v].run_en));
            check($sformatf("v%0d_alarm_time", v), 32'(alarm_time), 32'(vecs[v].alarm));
            check($sformatf("v%0d_alarm_en", v), 32'(alarm_en), 32'(vecs[v].al_en));
            check($sformatf("v%0d_inc_hour", v), 32'(cnt_h), 32'(vecs[v].inc[2]));
            check($sformatf("v%0d_inc_min", v), 32'(cnt_m), 32'(vecs[v].inc[1]));
            check($sformatf("v%0d_inc_sec", v), 32'(cnt_s), 32'(vecs[v].inc[0]));
            check($sformatf("v%0d_onehot", v), 32'(multi_hot), 32'd0);
            check($sformatf("v%0d_ring", v), 32'(ring), 32'd0);
        end

        // Blink stays low in RUN.
        tick();
        check("blink_run", 32'(blink), 32'd0);

        // Mode and inc together from RUN: mode wins, inc dropped.
        press(KM | KI);
        check("both_mode", 32'(mode), 32'd1);
        check("both_no_inc", 32'(cnt_h + cnt_m + cnt_s), 32'd0);
        check("both_alarm_en", 32'(alarm_en), 32'd0);

        // Blink toggles per tick in SET_HR and clears on a state change.
        tick();
        check("blink_tick1", 32'(blink), 32'd1);
        tick();
        check("blink_tick2", 32'(blink), 32'd0);
        tick();
        check("blink_tick3", 32'(blink), 32'd1);
        press(KM);
        check("blink_mode_chg", 32'(blink), 32'd0);
        check("bounce_state", 32'(mode), 32'd2);

        // Bouncing inc key in SET_MIN.
        clear_counts();
        for (int i = 0; i < 20; i++) begin
            btn_inc = ((i / 2) % 2 == 0);
            step(1);
        end
        check("bounce_no_early", 32'(cnt_m), 32'd0);
        btn_inc = 1'b1;
        first = -1;
        for (int i = 1; i <= DEB + 4; i++) begin
            step(1);
            if (cnt_m > 0 && first < 0) first = i;
        end
        check("bounce_in_window", 32'(first > 0), 32'd1);
        step(10);
        btn_inc = 1'b0;
        step(DEB + 8);
        check("bounce_one_pulse", 32'(cnt_m), 32'd1);
        check("bounce_other_inc", 32'(cnt_h + cnt_s), 32'd0);

        // Alarm hour: step to 23, wrap to 00, then on to 07.
        press(KM);
        press(KM);
        check("al_hr_mode", 32'(mode), 32'd4);
        hr = 1;
        mn = 1;
        for (int i = 0; i < 22; i++) begin
            press(KI);
            hr = (hr + 1) % 24;
            check("al_hr_step", 32'(alarm_time), 32'({to_bcd(hr), to_bcd(mn)}));
        end
        check("al_hr_23", 32'(alarm_time[15:8]), 32'h23);
        press(KI);
        hr = 0;
        check("al_hr_wrap", 32'(alarm_time[15:8]), 32'h00);
        for (int i = 0; i < 7; i++) begin
            press(KI);
            hr = hr + 1;
            check("al_hr_step", 32'(alarm_time), 32'({to_bcd(hr), to_bcd(mn)}));
        end

        // Alarm minute: step to 59, wrap to 00, then on to 30.
        press(KM);
        check("al_min_mode", 32'(mode), 32'd5);
        for (int i = 0; i < 58; i++) begin
            press(KI);
            mn = (mn + 1) % 60;
            check("al_min_step", 32'(alarm_time), 32'({to_bcd(hr), to_bcd(mn)}));
        end
        check("al_min_59", 32'(alarm_time[7:0]), 32'h59);
        press(KI);
        mn = 0;
        check("al_min_wrap", 32'(alarm_time[7:0]), 32'h00);
        for (int i = 0; i < 30; i++) begin
            press(KI);
            mn = mn + 1;
        end
        check("al_set_0730", 32'(alarm_time), 32'h0730);
        press(KM);
        press(KI);
        check("arm_mode", 32'(mode), 32'd0);
        check("arm_alarm_en", 32'(alarm_en), 32'd1);

        // Alarm trigger and self-clear after RSECS ticks.
        cur_time = 24'h072959;
        step(3);
        check("ring_before_match", 32'(ring), 32'd0);
        cur_time = 24'h073000;
        #1;
        check("ring_not_early", 32'(ring), 32'd0);
        step(1);
        check("ring_set", 32'(ring), 32'd1);
        for (int i = 0; i < RSECS - 1; i++) tick();
        check("ring_hold", 32'(ring), 32'd1);
        tick();
        check("ring_timeout", 32'(ring), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        step(10);
        check("ring_no_retrigger", 32'(ring), 32'd0);
        check("ring_alarm_en", 32'(alarm_en), 32'd1);

        // Stop press during ring.
        cur_time = 24'h073001;
        step(2);
        cur_time = 24'h073000;
        step(2);
        check("stop_ring_before", 32'(ring), 32'd1);
        press(KS);
        check("stop_ring_after", 32'(ring), 32'd0);
        check("stop_alarm_en", 32'(alarm_en), 32'd1);
        check("stop_mode", 32'(mode), 32'd0);

        // Reset mid-ring takes effect without a clock edge.
        cur_time = 24'h073001;
        step(2);
        cur_time = 24'h073000;
        step(2);
        check("rr_ring_before", 32'(ring), 32'd1);
        rst = 1'b0;
        #2;
        check("rr_mode", 32'(mode), 32'd0);
        check("rr_run_en", 32'(run_en), 32'd1);
        check("rr_inc", 32'({inc_hour, inc_min, inc_sec}), 32'd0);
        check("rr_alarm_time", 32'(alarm_time), 32'h0000);
        check("rr_alarm_en", 32'(alarm_en), 32'd0);
        check("rr_ring", 32'(ring), 32'd0);
        check("rr_blink", 32'(blink), 32'd0);
        step(3);
        rst = 1'b1;
        clear_counts();
        step(20);
        check("rr_ring_after", 32'(ring), 32'd0);
        check("rr_inc_after", 32'(cnt_h + cnt_m + cnt_s), 32'd0);

        // Reset between the debounced inc and its adjust pulse aborts the pulse.
        press(KM);
        check("adj_mode", 32'(mode), 32'd1);
        clear_counts();
        btn_inc = 1'b1;
        step(DEB + 3);
        rst = 1'b0;
        step(2);
        btn_inc = 1'b0;
        step(1);
        rst = 1'b1;
        step(20);
        check("adj_abort", 32'(cnt_h + cnt_m + cnt_s), 32'd0);
        check("adj_mode_after", 32'(mode), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
